// File: rtl/lcd_reader.sv
// lcd_reader: timed HD44780 read cycles (RW=1) for the DE2 LCD, 27 MHz clock.
// A single read returns the busy-flag/address-counter byte (rd_rs=0) or a
// DDRAM/CGRAM data byte (rd_rs=1). Poll mode repeats busy-flag reads until
// BF=0, or until POLL_MAX reads have been made, which reports a timeout.
//
// Ports:
//   clk          system clock (CLOCK_27)
//   rst          asynchronous, active-low reset
//   rd_req       start request, sampled only while idle
//   rd_rs        register select: 0 = BF/AC, 1 = data RAM
//   rd_poll      poll BF until clear (forces RS=0, ignores rd_rs)
//   rd_busy      high from the cycle after an accepted request until done
//   rd_done      one-cycle completion pulse
//   rd_data      last sampled byte, held until the next completion
//   rd_timeout   set with rd_done when a poll reached POLL_MAX reads
//   bus_own      top level muxes LCD_RW/RS/EN from here and tristates LCD_DATA
//   lcd_rs       LCD RS (valid while bus_own=1)
//   lcd_rw       LCD RW (valid while bus_own=1)
//   lcd_en       LCD E  (valid while bus_own=1)
//   lcd_data_in  LCD_DATA pins, read direction
module lcd_reader #(
  parameter int unsigned T_AS     = 2,
  parameter int unsigned T_PW     = 13,
  parameter int unsigned T_H      = 1,
  parameter int unsigned T_REC    = 14,
  parameter int unsigned POLL_MAX = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_req,
  input  logic       rd_rs,
  input  logic       rd_poll,
  output logic       rd_busy,
  output logic       rd_done,
  output logic [7:0] rd_data,
  output logic       rd_timeout,
  output logic       bus_own,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  input  logic [7:0] lcd_data_in
);

  localparam int unsigned PCW = (POLL_MAX > 2) ? $clog2(POLL_MAX) : 1;
  localparam logic [PCW:0] PLIM    = POLL_MAX[PCW:0];
  localparam logic [PCW:0] PONE    = {{PCW{1'b0}}, 1'b1};

  // Phase counter reload values: a state lasts (reload + 1) cycles.
  localparam logic [4:0] LD_AS  = 5'(T_AS - 1);
  localparam logic [4:0] LD_PW  = 5'(T_PW - 1);
  localparam logic [4:0] LD_H   = 5'(T_H - 1);
  localparam logic [4:0] LD_REC = 5'(T_REC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EN_HI,
    HOLD,
    RECOV,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [4:0]       phase, phase_nxt;
  logic [PCW-1:0]   poll_cnt, poll_cnt_nxt;
  logic [PCW:0]     poll_inc;
  logic             tmo_flag, tmo_nxt;
  logic             rs_eff, poll_mode;
  logic [7:0]       sample;
  logic             own_nxt, rs_nxt, en_nxt, accept, last_hi;

  assign poll_inc = {1'b0, poll_cnt} + PONE;

  always_comb begin
    state_nxt    = state;
    phase_nxt    = (phase != '0) ? phase - 5'd1 : '0;
    poll_cnt_nxt = poll_cnt;
    tmo_nxt      = tmo_flag;
    accept       = 1'b0;
    last_hi      = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req) begin
          accept       = 1'b1;
          state_nxt    = SETUP;
          phase_nxt    = LD_AS;
          poll_cnt_nxt = '0;
          tmo_nxt      = 1'b0;
        end
      end
      SETUP: begin
        if (phase == '0) begin
          state_nxt = EN_HI;
          phase_nxt = LD_PW;
        end
      end
      EN_HI: begin
        if (phase == '0) begin
          last_hi   = 1'b1;
          state_nxt = HOLD;
          phase_nxt = LD_H;
        end
      end
      HOLD: begin
        if (phase == '0) begin
          state_nxt = RECOV;
          phase_nxt = LD_REC;
        end
      end
      RECOV: begin
        if (phase == '0) begin
          if (poll_mode && sample[7] && (poll_inc < PLIM)) begin
            state_nxt    = SETUP;
            phase_nxt    = LD_AS;
            poll_cnt_nxt = poll_inc[PCW-1:0];
          end else begin
            state_nxt = DONE;
            phase_nxt = '0;
            if (poll_mode && sample[7]) tmo_nxt = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        phase_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
      end
    endcase

    // Outputs are registered from the next state so each line changes
    // exactly on the state-entry edge; RS comes straight from the request
    // on the accept edge because rs_eff is only being loaded then.
    own_nxt = (state_nxt != IDLE);
    en_nxt  = (state_nxt == EN_HI);
    rs_nxt  = accept ? (rd_poll ? 1'b0 : rd_rs) : rs_eff;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      phase      <= '0;
      poll_cnt   <= '0;
      tmo_flag   <= 1'b0;
      rs_eff     <= 1'b0;
      poll_mode  <= 1'b0;
      sample     <= '0;
      rd_busy    <= 1'b0;
      rd_done    <= 1'b0;
      rd_data    <= '0;
      rd_timeout <= 1'b0;
      bus_own    <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_rw     <= 1'b0;
      lcd_en     <= 1'b0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      poll_cnt <= poll_cnt_nxt;
      tmo_flag <= tmo_nxt;

      if (accept) begin
        rs_eff     <= rd_poll ? 1'b0 : rd_rs;
        poll_mode  <= rd_poll;
        rd_timeout <= 1'b0;
      end

      // Data is stable by the last EN-high cycle; no synchronizer needed.
      if (last_hi) sample <= lcd_data_in;

      bus_own <= own_nxt;
      rd_busy <= own_nxt;
      lcd_rw  <= own_nxt;
      lcd_rs  <= own_nxt & rs_nxt;
      lcd_en  <= en_nxt;
      rd_done <= (state == DONE);

      if (state == DONE) begin
        rd_data    <= sample;
        rd_timeout <= tmo_flag;
      end
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
module tb_lcd_reader;

  typedef struct {
    logic [7:0] data;
    logic       tmo;
    int         lat;
    int         pulses;
    logic       rs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rd_req = 1'b0;
  logic       rd_rs = 1'b0;
  logic       rd_poll = 1'b0;
  logic       rd_busy, rd_done, rd_timeout, bus_own, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] rd_data;
  logic [7:0] lcd_data_in;

  logic [7:0] resp [4];
  logic [1:0] pidx = 2'd0;
  logic       en_d = 1'b0;
  logic       own_d = 1'b0;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_dones = 0;
  int   n_done = 0;
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  lcd_reader #(
    .T_AS(2), .T_PW(13), .T_H(1), .T_REC(14), .POLL_MAX(4)
  ) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_rs(rd_rs), .rd_poll(rd_poll),
    .rd_busy(rd_busy), .rd_done(rd_done), .rd_data(rd_data),
    .rd_timeout(rd_timeout), .bus_own(bus_own), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data_in(lcd_data_in)
  );

  // LCD model: returns resp[n] on the n-th EN pulse of a bus ownership.
  assign lcd_data_in = resp[pidx];

  always @(posedge clk) begin
    en_d  <= lcd_en;
    own_d <= bus_own;
    if (bus_own && !own_d) pidx <= 2'd0;
    else if (en_d && !lcd_en && pidx != 2'd3) pidx <= pidx + 2'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard consumer.
  initial begin : monitor
    exp_t e;
    int   cyc, acc, last_rise, npulse, first_off, min_per;
    bit   active, ctrl_bad, width_bad, eo_bad, en_q, own_q, done_q, rst_q;
    logic exp_rs;
    cyc = 0; acc = 0; last_rise = 0; npulse = 0; first_off = 0; min_per = 1000;
    active = 0; ctrl_bad = 0; width_bad = 0; eo_bad = 0;
    en_q = 0; own_q = 0; done_q = 0; rst_q = 0; exp_rs = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("reset_state",
          32'({rd_busy, rd_done, rd_timeout, bus_own, lcd_en, lcd_rs, lcd_rw, rd_data}), 32'h0);

    while (!stim_done && cyc <= 3000) begin
      @(negedge clk or negedge rst);
      if (rst_q && !rst) begin
        #1;
        check("async_reset", 32'({lcd_en, bus_own, rd_busy, rd_done}), 32'h0);
        if (active && sb.size() != 0) e = sb.pop_front();
        active = 0; en_q = 0; own_q = 0; done_q = 0;
      end else if (rst) begin
        cyc++;
        if (done_q) check("done_one_cycle", 32'(rd_done), 32'h0);
        if (active && !rd_done) begin
          if (cyc > acc && (!bus_own || !rd_busy || lcd_rw !== 1'b1 || lcd_rs !== exp_rs))
            ctrl_bad = 1;
          if (lcd_en && !en_q) begin
            npulse++;
            if (npulse == 1) first_off = cyc - acc;
            else if (cyc - last_rise < min_per) min_per = cyc - last_rise;
            last_rise = cyc;
          end
          if (!lcd_en && en_q && (cyc - last_rise != 13)) width_bad = 1;
        end
        if (lcd_en && !bus_own) eo_bad = 1;
        if (rd_done) begin
          if (sb.size() == 0) begin
            check("spurious_done", 32'h1, 32'h0);
          end else begin
            e = sb.pop_front();
            check("rd_data", 32'(rd_data), 32'(e.data));
            check("rd_timeout", 32'(rd_timeout), 32'(e.tmo));
            check("latency", cyc - acc, e.lat);
            check("en_pulses", npulse, e.pulses);
            if (npulse > 0) check("en_first_rise", first_off, 3);
            check("en_width_13", 32'(width_bad), 32'h0);
            if (npulse > 1) check("en_period_ge28", 32'(min_per >= 28), 32'h1);
            check("ctrl_lines", 32'(ctrl_bad), 32'h0);
            check("release_with_done", 32'({bus_own, rd_busy, own_q}), 32'h1);
            check("en_without_own", 32'(eo_bad), 32'h0);
          end
          n_done++;
          active = 0;
        end
        if (rd_req && !rd_busy) begin
          active = 1; acc = cyc; npulse = 0; min_per = 1000;
          width_bad = 0; ctrl_bad = 0; eo_bad = 0;
          exp_rs = (sb.size() != 0) ? sb[0].rs : 1'b0;
        end
        en_q = lcd_en; own_q = bus_own; done_q = rd_done;
      end
      rst_q = rst;
    end

    if (cyc > 3000) check("watchdog_cycles", cyc, 0);
    check("done_count", n_done, exp_dones);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Stimulus / scoreboard producer.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_resp(input logic [7:0] a, b, c, d);
    resp[0] = a; resp[1] = b; resp[2] = c; resp[3] = d;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic t, input int lat,
                          input int np, input logic rs_x, input bit counted);
    exp_t e;
    e.data = d; e.tmo = t; e.lat = lat; e.pulses = np; e.rs = rs_x;
    sb.push_back(e);
    if (counted) exp_dones++;
  endtask

  task automatic issue(input logic rs_i, input logic poll_i, input logic [7:0] d,
                       input logic t, input int lat, input int np, input logic rs_x);
    push_exp(d, t, lat, np, rs_x, 1'b1);
    rd_rs = rs_i; rd_poll = poll_i; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && (rd_busy || sb.size() != 0); i++) tick();
    tick();
  endtask

  initial begin : stimulus
    set_resp(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();

    // single BF read
    set_resp(8'h2A, 8'h2A, 8'h2A, 8'h2A);
    issue(1'b0, 1'b0, 8'h2A, 1'b0, 32, 1, 1'b0);
    wait_idle();

    // data RAM read
    set_resp(8'h41, 8'h41, 8'h41, 8'h41);
    issue(1'b1, 1'b0, 8'h41, 1'b0, 32, 1, 1'b1);
    wait_idle();

    // poll: busy, busy, clear; rd_rs=1 must be ignored
    set_resp(8'hC0, 8'hC0, 8'h05, 8'h05);
    issue(1'b1, 1'b1, 8'h05, 1'b0, 92, 3, 1'b0);
    wait_idle();

    // poll timeout with POLL_MAX=4
    set_resp(8'h80, 8'h80, 8'h80, 8'h80);
    issue(1'b0, 1'b1, 8'h80, 1'b1, 122, 4, 1'b0);
    wait_idle();

    // timeout flag cleared by the next transaction
    set_resp(8'h13, 8'h13, 8'h13, 8'h13);
    issue(1'b0, 1'b0, 8'h13, 1'b0, 32, 1, 1'b0);
    wait_idle();

    // request while busy is ignored
    set_resp(8'h55, 8'h55, 8'h55, 8'h55);
    issue(1'b0, 1'b0, 8'h55, 1'b0, 32, 1, 1'b0);
    repeat (4) tick();
    rd_rs = 1'b1; rd_req = 1'b1;
    tick();
    rd_req = 1'b0; rd_rs = 1'b0;
    wait_idle();

    // rd_req held across DONE: second transaction starts right after
    set_resp(8'h3C, 8'h3C, 8'h3C, 8'h3C);
    push_exp(8'h3C, 1'b0, 32, 1, 1'b1, 1'b1);
    push_exp(8'h3C, 1'b0, 32, 1, 1'b1, 1'b1);
    rd_rs = 1'b1; rd_poll = 1'b0; rd_req = 1'b1;
    tick();
    for (int i = 0; i < 100 && !rd_done; i++) tick();
    tick();
    rd_req = 1'b0; rd_rs = 1'b0;
    wait_idle();

    // reset asserted during EN high: transaction aborted, no rd_done
    set_resp(8'h77, 8'h77, 8'h77, 8'h77);
    push_exp(8'h77, 1'b0, 32, 1, 1'b1, 1'b0);
    rd_rs = 1'b1; rd_poll = 1'b0; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < 50 && !lcd_en; i++) tick();
    repeat (3) tick();
    #2 rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // normal read after reset release
    set_resp(8'h99, 8'h99, 8'h99, 8'h99);
    issue(1'b0, 1'b0, 8'h99, 1'b0, 32, 1, 1'b0);
    wait_idle();

    repeat (3) tick();
    stim_done = 1'b1;
  end

endmodule

// File: doc/lcd_reader.md
Name: lcd_reader

Overview:
- Read-side companion to the HD44780 LCD write path on the DE2 board (27 MHz clock).
- Performs timed HD44780 read cycles (RW=1): either a single read of the busy-flag/address-counter or DDRAM/CGRAM data, or a busy-flag poll that repeats until BF=0.
- Owns the LCD bus only while a transaction is active. bus_own tells the top level to mux LCD_RW/LCD_RS/LCD_EN from this block and to tristate LCD_DATA.
- The processor uses it in place of fixed delays so that further writes wait on the real busy state.

Parameters:
- T_AS, 2: cycles of RS/RW setup before EN rises (≥40 ns).
- T_PW, 13: cycles EN is held high (≥450 ns). Data is sampled on the last high cycle.
- T_H, 1: cycles RS/RW are held after EN falls.
- T_REC, 14: extra EN-low cycles before the next EN rise or release (EN cycle ≥1000 ns).
- POLL_MAX, 4096: maximum busy-flag reads in poll mode before timeout.

Ports:
- clk  input  1  system clock (CLOCK_27).
- rst  input  1  asynchronous, active-low reset.
- rd_req  input  1  start request; sampled only in IDLE.
- rd_rs  input  1  register select: 0 = BF/AC, 1 = data RAM.
- rd_poll  input  1  1 = poll BF until clear (forces RS=0, ignores rd_rs).
- rd_busy  output  1  high from the cycle after an accepted request until done.
- rd_done  output  1  one-cycle pulse when a transaction completes.
- rd_data  output  8  last sampled byte; held until the next completion.
- rd_timeout  output  1  set with rd_done when a poll hit POLL_MAX; cleared on the next accept.
- bus_own  output  1  high while this block drives the LCD control lines.
- lcd_rs  output  1  LCD RS when bus_own=1.
- lcd_rw  output  1  LCD RW when bus_own=1.
- lcd_en  output  1  LCD E when bus_own=1.
- lcd_data_in  input  8  LCD_DATA pins, read direction.

Behaviour:
- Reset values (rst=0, asynchronous):
  - state=IDLE.
  - rd_busy, rd_done, rd_timeout, bus_own, lcd_en, lcd_rs = 0.
  - lcd_rw = 0, rd_data = 8'h00.
  - All counters = 0.
- Reset mid-transaction: everything returns to the reset values immediately. EN drops at once and bus_own drops at once. No rd_done is issued.
- All outputs are registered.
- State machine: IDLE -> SETUP -> EN_HI -> HOLD -> RECOV -> (SETUP | DONE) -> IDLE.
- IDLE:
  - Condition: rd_req=1.
  - Latch rs_eff = rd_poll ? 0 : rd_rs, and latch poll_mode.
  - Clear poll_cnt and rd_timeout.
  - Next cycle: bus_own=1, lcd_rw=1, lcd_rs=rs_eff, rd_busy=1; go to SETUP.
- SETUP:
  - Wait T_AS cycles with lcd_en=0, then go to EN_HI.
- EN_HI:
  - lcd_en=1 for exactly T_PW cycles.
  - On the final cycle, register lcd_data_in into a sample register. It is a 2-flop synchronizer-free capture; data is stable by then.
- HOLD:
  - lcd_en=0; RS/RW unchanged for T_H cycles.
- RECOV (T_REC cycles):
  - EN stays 0.
  - Poll mode with sample[7]=1 and poll_cnt+1 < POLL_MAX: increment poll_cnt, go to SETUP. bus_own stays high.
  - Poll mode with sample[7]=1 and poll_cnt+1 == POLL_MAX: set timeout flag, go to DONE.
  - Otherwise: go to DONE.
- DONE (1 cycle):
  - rd_data <= sample.
  - rd_done=1, rd_timeout <= timeout flag.
  - rd_busy=0, bus_own=0, lcd_rw=0, lcd_rs=0.
  - Go to IDLE.
- Latency:
  - Single read: 1 (accept) + T_AS + T_PW + T_H + T_REC + 1 = 32 cycles from the rd_req sample to rd_done with defaults.
  - Poll: 30 additional cycles per extra read.
- rd_req while rd_busy=1 is ignored; no queueing.
- rd_req held high across DONE starts a new transaction the cycle after DONE. There is never a back-to-back EN within T_REC.
- rd_data is the full 8-bit byte. In BF mode, bit 7 = BF and bits 6:0 = address counter.
- Counters:
  - The phase counter is 5 bits wide, saturating, and reloaded on each state entry.
  - poll_cnt is clog2(POLL_MAX) bits wide.
- lcd_en never rises while bus_own=0. bus_own never falls while lcd_en=1.

Test Plan:
- Single BF read:
  - Stimulus: reset released, rd_req=1 with rd_rs=0 and rd_poll=0; LCD model drives 8'h2A.
  - Required: lcd_rw=1 and lcd_rs=0 for the whole transaction; one EN pulse 13 cycles wide starting 2 cycles after SETUP entry; rd_done 32 cycles after accept; rd_data=8'h2A; rd_timeout=0.
- Data read:
  - Stimulus: rd_rs=1; model drives 8'h41.
  - Required: lcd_rs=1 throughout; rd_data=8'h41; bus_own falls in the same cycle as rd_done.
- Poll:
  - Stimulus: rd_poll=1; model returns 8'hC0, 8'hC0, then 8'h05.
  - Required: exactly 3 EN pulses, each EN period ≥28 cycles; rd_done at cycle 92; rd_data=8'h05; rd_timeout=0.
- Timeout:
  - Stimulus: POLL_MAX=4; model always returns 8'h80.
  - Required: exactly 4 EN pulses, then rd_done with rd_timeout=1 and rd_data=8'h80.
- Reset mid-EN:
  - Stimulus: assert rst=0 during EN_HI.
  - Required: lcd_en, bus_own and rd_busy go to 0 asynchronously; no rd_done; a new rd_req after release completes normally.
- Request while busy:
  - Stimulus: pulse rd_req 5 cycles after accept, with rd_rs toggled.
  - Required: ignored; the transaction keeps its original RS; exactly one rd_done.
